// File: rtl/dac_tx_pkg.sv
// Shared definitions for the LVDS DAC transmit path (framer and output stage).
// Holds the framer state encoding, the DAC word width and the mid-scale code
// used whenever no real sample is available.
package dac_tx_pkg;

  localparam int unsigned DAC_DATA_W = 12;
  localparam logic [DAC_DATA_W-1:0] DAC_IDLE_CODE = 12'h800;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } dac_tx_state_e;

  // RUN and DRAIN behave identically on the output side.
  function automatic logic is_streaming(input dac_tx_state_e st);
    return (st == ST_RUN) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous clear (pointers and level to zero)
//   wr_en/wr_data write request and data (ignored when full)
//   rd_en         pop request (ignored when empty)
//   rd_data       head word, valid whenever !empty
//   full, empty   status from the registered level
//   level         current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (do_wr && !clr && !rst) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/dac_tx_framer.sv
// DAC transmit framer: buffers source samples in a small FIFO and emits one
// word per clock to the LVDS stage, with a strobe on the first word of each
// frame. Empty cycles while streaming are filled with the mid-scale code so
// frame timing never slips.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            level request to stream
//   s_data/s_valid    source sample stream
//   s_ready           space available and not idle
//   tx_data           registered output word
//   tx_strobe         registered, high with word 0 of each frame
//   running           registered, high in RUN or DRAIN
//   fifo_level        FIFO occupancy
//   underrun_cnt      saturating count of inserted idle words
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | FIFO held clear, outputs idle, waits for enable
// ST_PRIME | FIFO fills until PRIME_LEVEL, no output words
// ST_RUN   | one word per cycle, frame counter running
// ST_DRAIN | as RUN, enable dropped; finishes current frame then IDLE
module dac_tx_framer
  import dac_tx_pkg::*;
#(
  parameter int unsigned         DATA_W      = DAC_DATA_W,
  parameter int unsigned         FIFO_DEPTH  = 16,
  parameter int unsigned         PRIME_LEVEL = 8,
  parameter int unsigned         FRAME_LEN   = 64,
  parameter logic [DATA_W-1:0]   IDLE_CODE   = DAC_IDLE_CODE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_W-1:0]             tx_data,
  output logic                          tx_strobe,
  output logic                          running,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_cnt
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  dac_tx_state_e     state_q, state_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_strobe_q, tx_strobe_d;
  logic              running_q, running_d;
  logic [15:0]       underrun_q, underrun_d;

  logic              fifo_clr;
  logic              fifo_wr;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_lvl;
  logic              frame_last;
  logic              streaming;

  // Readiness looks only at the registered count: a pop in the same cycle
  // does not open a slot until the next cycle.
  assign s_ready = (state_q != ST_IDLE) && !fifo_full;
  assign fifo_wr = s_valid && s_ready;

  // Entering (or staying in) IDLE discards anything still buffered.
  assign fifo_clr = (state_d == ST_IDLE);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (fifo_clr),
    .wr_en   (fifo_wr),
    .wr_data (s_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_lvl)
  );

  assign streaming  = is_streaming(state_q);
  assign frame_last = (frame_cnt_q == CNT_W'(FRAME_LEN - 1));

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = '0;
    tx_data_d   = IDLE_CODE;
    tx_strobe_d = 1'b0;
    underrun_d  = underrun_q;
    fifo_rd     = 1'b0;

    if (streaming) begin
      fifo_rd     = !fifo_empty;
      tx_data_d   = fifo_empty ? IDLE_CODE : fifo_rdata;
      tx_strobe_d = (frame_cnt_q == '0);
      frame_cnt_d = frame_last ? '0 : frame_cnt_q + 1'b1;
      if (fifo_empty && (underrun_q != 16'hFFFF)) begin
        underrun_d = underrun_q + 16'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (fifo_lvl >= LVL_W'(PRIME_LEVEL)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Dropping enable on the last word of a frame needs no DRAIN pass.
        if (!enable) state_d = frame_last ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (frame_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    running_d = is_streaming(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      tx_data_q   <= IDLE_CODE;
      tx_strobe_q <= 1'b0;
      running_q   <= 1'b0;
      underrun_q  <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_strobe_q <= tx_strobe_d;
      running_q   <= running_d;
      underrun_q  <= underrun_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_strobe    = tx_strobe_q;
  assign running      = running_q;
  assign fifo_level   = fifo_lvl;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_dac_tx_framer.sv
// Directed bench for dac_tx_framer: default instance plus a PRIME_LEVEL=16
// instance used for the fill-to-full case.
module tb_dac_tx_framer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [11:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] tx_data;
  logic        tx_strobe;
  logic        running;
  logic [4:0]  fifo_level;
  logic [15:0] underrun_cnt;

  logic        en16;
  logic [11:0] sd16;
  logic        sv16;
  logic        sr16;
  logic [11:0] tx16;
  logic        stb16;
  logic        run16;
  logic [4:0]  lvl16;
  logic [15:0] ur16;

  int tests_run    = 0;
  int tests_failed = 0;
  int src          = 0;
  int src16        = 0;

  dac_tx_framer u_dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .tx_data      (tx_data),
    .tx_strobe    (tx_strobe),
    .running      (running),
    .fifo_level   (fifo_level),
    .underrun_cnt (underrun_cnt)
  );

  dac_tx_framer #(.PRIME_LEVEL(16)) u_dut16 (
    .clk          (clk),
    .rst          (rst),
    .enable       (en16),
    .s_data       (sd16),
    .s_valid      (sv16),
    .s_ready      (sr16),
    .tx_data      (tx16),
    .tx_strobe    (stb16),
    .running      (run16),
    .fifo_level   (lvl16),
    .underrun_cnt (ur16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; counting sources advance only on an accepted handshake.
  task automatic tick();
    logic a1, a2;
    a1 = s_valid && s_ready;
    a2 = sv16 && sr16;
    @(posedge clk);
    #1;
    if (a1) begin src++;   s_data = 12'(src);   end
    if (a2) begin src16++; sd16   = 12'(src16); end
  endtask

  // From IDLE: enable with an always-valid source, walk through PRIME to RUN.
  task automatic prime8();
    enable  = 1'b1;
    s_valid = 1'b1;
    tick();
    chk("prime_entry_running", running, 0);
    chk("prime_entry_ready", s_ready, 1);
    chk("prime_entry_level", fifo_level, 0);
    repeat (8) tick();
    chk("prime_level8", fifo_level, 8);
    chk("prime_still_not_running", running, 0);
    chk("prime_tx_idle", tx_data, 12'h800);
    tick();
    chk("run_entry_running", running, 1);
    chk("run_entry_level", fifo_level, 9);
    chk("run_entry_no_strobe", tx_strobe, 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    en16 = 1'b0; sv16 = 1'b0; sd16 = '0;
    repeat (3) tick();
    chk("rst_tx_data", tx_data, 12'h800);
    chk("rst_tx_strobe", tx_strobe, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_running", running, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_underrun", underrun_cnt, 0);
    rst = 1'b0;
    tick();

    // PRIME_LEVEL=16: fill to full, then no loss/dup across RUN entry.
    en16 = 1'b1; sv16 = 1'b1;
    tick();
    chk("p16_prime_ready", sr16, 1);
    repeat (16) tick();
    chk("p16_level_full", lvl16, 16);
    chk("p16_ready_at_full", sr16, 0);
    chk("p16_not_running", run16, 0);
    tick();
    chk("p16_run_entry", run16, 1);
    chk("p16_run_entry_level", lvl16, 16);
    chk("p16_run_entry_ready", sr16, 0);
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("p16_data", tx16, k);
      chk("p16_strobe", stb16, (k == 0) ? 1 : 0);
      if (k == 0) chk("p16_level_after_pop", lvl16, 15);
    end
    chk("p16_no_underrun", ur16, 0);
    en16 = 1'b0; sv16 = 1'b0;

    // Continuous source, contiguous data; enable dropped at frame count 10.
    prime8();
    for (int k = 0; k < 192; k++) begin
      tick();
      chk("t1_data", tx_data, k);
      chk("t1_strobe", tx_strobe, ((k % 64) == 0) ? 1 : 0);
      chk("t1_running", running, (k == 191) ? 0 : 1);
      if (k == 137) enable = 1'b0;
    end
    chk("t3_idle_ready", s_ready, 0);
    chk("t3_idle_level", fifo_level, 0);
    tick();
    chk("t3_idle_tx", tx_data, 12'h800);
    chk("t3_idle_strobe", tx_strobe, 0);

    // Source valid every other cycle: FIFO drains, idle words inserted.
    src = 0; s_data = '0;
    prime8();
    for (int i = 0; i < 130; i++) begin
      int ed, eu;
      s_valid = (i % 2 == 1);
      ed = (i <= 16) ? i : ((i % 2 == 1) ? 'h800 : (i / 2 + 8));
      eu = (i < 17) ? 0 : ((i - 17) / 2 + 1);
      tick();
      chk("t2_data", tx_data, ed);
      chk("t2_strobe", tx_strobe, ((i % 64) == 0) ? 1 : 0);
      chk("t2_underrun", underrun_cnt, eu);
    end
    enable = 1'b0; s_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (running === 1'b1 && n < 100) begin
        tick();
        n++;
      end
      chk("t2_drain_done", running, 0);
    end

    // Reset mid-frame with FIFO at 9.
    src = 0; s_data = '0;
    prime8();
    repeat (5) tick();
    chk("t5_level9", fifo_level, 9);
    rst = 1'b1;
    tick();
    chk("t5_tx_data", tx_data, 12'h800);
    chk("t5_strobe", tx_strobe, 0);
    chk("t5_level", fifo_level, 0);
    chk("t5_underrun", underrun_cnt, 0);
    chk("t5_running", running, 0);
    chk("t5_ready", s_ready, 0);
    rst = 1'b0; enable = 1'b0; s_valid = 1'b0;
    tick();

    // Starve the source until underrun_cnt saturates.
    src = 0; s_data = '0;
    prime8();
    s_valid = 1'b0;
    for (int i = 0; i <= 65548; i++) begin
      tick();
      if (i == 8)     chk("sat_last_data", tx_data, 8);
      if (i == 8)     chk("sat_cnt0", underrun_cnt, 0);
      if (i == 9)     chk("sat_cnt1", underrun_cnt, 1);
      if (i == 65536) chk("sat_strobe_on", tx_strobe, 1);
      if (i == 65537) chk("sat_strobe_off", tx_strobe, 0);
      if (i == 65542) chk("sat_fffe", underrun_cnt, 16'hFFFE);
      if (i == 65543) chk("sat_ffff", underrun_cnt, 16'hFFFF);
      if (i == 65548) chk("sat_hold", underrun_cnt, 16'hFFFF);
      if (i == 65548) chk("sat_idle_code", tx_data, 12'h800);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
